// File: rtl/mem_pkg.sv
// Shared types and limits for the lane-based SRAM controller.
// Holds default geometry, latency bounds and the read tag bundle.
package mem_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_LANE_WIDTH = 16;
  localparam int NUM_LANES      = DEF_XLEN / DEF_LANE_WIDTH;
  localparam int LANE_BYTES     = DEF_LANE_WIDTH / 8;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 4;

  // Wide enough for any practical word address; top truncates.
  localparam int TAG_ADDR_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [TAG_ADDR_W-1:0] addr;
  } rd_tag_t;

  function automatic int num_lanes(int xlen, int lw);
    return xlen / lw;
  endfunction

  function automatic int lane_bytes(int lw);
    return lw / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-ack alignment pipe: tag shift register plus data delay stages.
// Ports: clk_i, rst_ni, flush_i, tag_i, data_i (RAM out), tag_o, data_o.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  rd_tag_t      tag_i,
  input  logic [W-1:0] data_i,
  output rd_tag_t      tag_o,
  output logic [W-1:0] data_o
);

  rd_tag_t tag_q [DEPTH];
  rd_tag_t tag_d [DEPTH];

  always_comb begin
    tag_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      tag_d[i].valid = tag_d[i].valid & ~flush_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign tag_o = tag_q[DEPTH-1];

  if (DEPTH == 1) begin : g_direct
    assign data_o = data_i;
  end else begin : g_stages
    // data_q[j] sits beside tag_q[j+1]; a stage loads only
    // when a live read moves into it, so the output holds.
    logic [W-1:0] data_q [DEPTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j < DEPTH-1; j++) data_q[j] <= '0;
      end else if (!flush_i) begin
        if (tag_q[0].valid) data_q[0] <= data_i;
        for (int j = 1; j < DEPTH-1; j++) begin
          if (tag_q[j].valid) data_q[j] <= data_q[j-1];
        end
      end
    end

    assign data_o = data_q[DEPTH-2];
  end

endmodule

// File: rtl/single_port_ram.sv
// Byte-writable single-port lane RAM with a registered read port.
// Ports: clk_i, en_i, we_i (byte strobes), addr_i, wdata_i, rdata_o.
module single_port_ram #(
  parameter int DW    = 16,
  parameter int AW    = 14,
  parameter int WORDS = 16384
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;

  // Output register only moves on reads, so it holds between them.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|we_i) begin
        for (int b = 0; b < DW/8; b++) begin
          if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/single_port_ram_sim.sv
// Behavioural lane RAM for simulation; same timing as single_port_ram.
// Ports: clk_i, en_i, we_i (byte strobes), addr_i, wdata_i, rdata_o.
module single_port_ram_sim #(
  parameter int DW    = 16,
  parameter int AW    = 14,
  parameter int WORDS = 16384
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mask;

  always_comb begin
    mask = '0;
    for (int b = 0; b < DW/8; b++) begin
      mask[b*8 +: 8] = {8{we_i[b]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|we_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & ~mask)
                       | (wdata_i & mask);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_controller_pipe.sv
// SRAM controller: N lane RAMs, range check, collision error, aligned acks.
// Ports: clk, reset_n, sync_reset, mem_* request in, read/write ack out.
module mem_controller_pipe
  import mem_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int LANE_WIDTH     = DEF_LANE_WIDTH,
  parameter int ADDR_BITS      = 16,
  parameter int SRAM_ADDR_BITS = 14,
  parameter int SRAM_WORDS     = 16384,
  parameter int READ_LATENCY   = 3,
  parameter int sim            = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic [XLEN/8-1:0]    mem_write_en,
  input  logic [XLEN-1:0]      mem_write_data,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 mem_read_ack,
  output logic                 mem_write_ack,
  output logic [ADDR_BITS-1:0] mem_addr_ack,
  output logic                 mem_err
);

  localparam int NL = num_lanes(XLEN, LANE_WIDTH);
  localparam int LB = lane_bytes(LANE_WIDTH);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_lat
    $error("READ_LATENCY must be within 1..4");
  end
  if (XLEN % LANE_WIDTH != 0) begin : g_bad_lane
    $error("XLEN must be a multiple of LANE_WIDTH");
  end
  if (SRAM_WORDS > (1 << SRAM_ADDR_BITS)) begin : g_bad_words
    $error("SRAM_WORDS exceeds 2^SRAM_ADDR_BITS");
  end

  logic                      in_range;
  logic                      wr_any;
  logic                      rd_req;
  logic                      rd_err;
  logic                      ram_rd;
  logic [SRAM_ADDR_BITS-1:0] ram_addr;
  logic [XLEN-1:0]           ram_rdata;
  logic [XLEN-1:0]           ram_masked;

  logic    rd_ok_q, rd_ok_d;
  logic    wr_ack_q, wr_ack_d;
  logic    wr_err_q, wr_err_d;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  assign in_range = 32'(mem_addr) < 32'(SRAM_WORDS);
  assign wr_any   = (|mem_write_en) & ~sync_reset;
  assign rd_req   = mem_read_en & ~sync_reset;

  // A read sharing its cycle with a write is refused.
  assign rd_err   = ~in_range | (|mem_write_en);
  assign ram_rd   = rd_req & ~rd_err;
  assign ram_addr = mem_addr[SRAM_ADDR_BITS-1:0];

  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic [LB-1:0] lane_we;
    logic          lane_en;

    assign lane_we = (in_range && !sync_reset)
                   ? mem_write_en[k*LB +: LB] : '0;
    assign lane_en = ram_rd | (|lane_we);

    if (sim != 0) begin : g_sim
      single_port_ram_sim #(
        .DW(LANE_WIDTH), .AW(SRAM_ADDR_BITS), .WORDS(SRAM_WORDS)
      ) u_ram (
        .clk_i  (clk),
        .en_i   (lane_en),
        .we_i   (lane_we),
        .addr_i (ram_addr),
        .wdata_i(mem_write_data[k*LANE_WIDTH +: LANE_WIDTH]),
        .rdata_o(ram_rdata[k*LANE_WIDTH +: LANE_WIDTH])
      );
    end else begin : g_syn
      single_port_ram #(
        .DW(LANE_WIDTH), .AW(SRAM_ADDR_BITS), .WORDS(SRAM_WORDS)
      ) u_ram (
        .clk_i  (clk),
        .en_i   (lane_en),
        .we_i   (lane_we),
        .addr_i (ram_addr),
        .wdata_i(mem_write_data[k*LANE_WIDTH +: LANE_WIDTH]),
        .rdata_o(ram_rdata[k*LANE_WIDTH +: LANE_WIDTH])
      );
    end
  end

  // Remembers whether the latest read was served by the RAM;
  // refused reads then see zero instead of stale RAM output.
  always_comb begin
    rd_ok_d  = rd_ok_q;
    if (rd_req) rd_ok_d = ~rd_err;
    wr_ack_d = wr_any;
    wr_err_d = wr_any & ~in_range;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ok_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      rd_ok_q  <= rd_ok_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign ram_masked = rd_ok_q ? ram_rdata : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = rd_req;
    tag_in.err   = rd_err;
    tag_in.addr  = TAG_ADDR_W'(mem_addr);
  end

  mem_rd_pipe #(
    .DEPTH(READ_LATENCY),
    .W    (XLEN)
  ) u_rd_pipe (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .flush_i(sync_reset),
    .tag_i  (tag_in),
    .data_i (ram_masked),
    .tag_o  (tag_out),
    .data_o (mem_read_data)
  );

  logic unused_tag_hi;
  assign unused_tag_hi = ^tag_out.addr[TAG_ADDR_W-1:ADDR_BITS];

  assign mem_read_ack  = tag_out.valid;
  assign mem_addr_ack  = tag_out.addr[ADDR_BITS-1:0];
  assign mem_write_ack = wr_ack_q;
  assign mem_err       = (tag_out.valid & tag_out.err)
                       | (wr_ack_q & wr_err_q);

endmodule

// File: doc/mem_controller_pipe.md
Name: mem_controller_pipe

Overview:
Parametrised successor to the on-chip SRAM memory controller. It serves single-cycle read and write requests from the core memory port and builds an XLEN-wide word from N lane RAMs, each LANE_WIDTH bits wide. It returns read data, read ack and the ack address, all aligned after a configurable pipeline latency. New over the previous generation: address range checking with an error response, read/write collision detection, sync_reset flushing, and an ack address aligned with the ack.

Parameters:
XLEN, 32, data word width in bits; a multiple of LANE_WIDTH and of 8
LANE_WIDTH, 16, width of each lane RAM; a multiple of 8
ADDR_BITS, 16, word address width of mem_addr
SRAM_ADDR_BITS, 14, address bits driven into each lane RAM
SRAM_WORDS, 16384, populated words; must be <= 2^SRAM_ADDR_BITS
READ_LATENCY, 3, cycles from read request to ack; legal range 1..4
sim, 0, 0 selects the synthesis RAM, 1 selects the simulation RAM models

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sync_reset  input  1  synchronous flush of the ack pipelines; RAM contents are untouched
mem_addr  input  ADDR_BITS  word address
mem_read_en  input  1  read request strobe, one cycle per request
mem_write_en  input  XLEN/8  byte write enables
mem_write_data  input  XLEN  write data
mem_read_data  output  XLEN  read data, valid when mem_read_ack=1
mem_read_ack  output  1  read completion pulse
mem_write_ack  output  1  write completion pulse
mem_addr_ack  output  ADDR_BITS  address of the read being acked
mem_err  output  1  error flag, qualified by mem_read_ack or mem_write_ack

Behaviour:
- Reset (reset_n=0, asynchronous): every output register goes to 0, i.e. read_data, both acks, addr_ack and err; all pipeline valid bits clear.
- sync_reset=1 at a clock edge: all pipeline valid bits, acks and err clear; an in-flight read is dropped and never acked; a request presented in the same cycle is ignored.
- Lanes: lane k covers data bits [k*LANE_WIDTH +: LANE_WIDTH]. Lane write strobe bits = mem_write_en[k*LANE_WIDTH/8 +: LANE_WIDTH/8]. Each lane RAM has a registered output, so data is available 1 cycle after the address.
- Range check: in_range = (mem_addr < SRAM_WORDS). When out of range, every lane write enable is forced to 0.
- Write: request when any mem_write_en bit is set. mem_write_ack pulses 1 cycle later. mem_err = ~in_range on that ack.
- Read: request presented at cycle T. mem_read_ack=1 at T+READ_LATENCY together with data, mem_addr_ack = the request address, and mem_err.
  - Data comes from the RAM output at T+1, then passes through READ_LATENCY-1 delay stages.
  - With READ_LATENCY=1 the RAM output drives mem_read_data directly.
- Out-of-range read: ack at the same latency, mem_read_data = 0, mem_err = 1.
- Collision: mem_read_en together with a nonzero mem_write_en in the same cycle.
  - The write executes.
  - The read is acked at normal latency with mem_err=1 and data 0.
  - mem_write_ack also pulses, with err = ~in_range.
  - If both acks fall in the same cycle, mem_err is the OR of the two.
- Back-to-back reads: one per cycle, fully pipelined; acks come out in request order, one per cycle.
- A read at T followed by a write to the same address at T+1: the read returns the old data. There is no forwarding; the RAM is read-first per request cycle.
- Outside an ack cycle, mem_read_data holds its last value and mem_err=0.
- Elaboration errors ($error) for: READ_LATENCY outside 1..4, XLEN % LANE_WIDTH != 0, SRAM_WORDS > 2^SRAM_ADDR_BITS.

Decomposition:
- Shared package mem_pkg holds: lane count constant NUM_LANES = XLEN/LANE_WIDTH, bytes per lane, the READ_LATENCY bounds, and a packed struct rd_tag_t {valid, err, addr}.
- Sub-module mem_rd_pipe, parametrised by depth and width: a shift register of rd_tag_t plus the data delay stages, with sync flush.
- Lane RAMs are instantiated in a generate loop from the existing single_port_ram, or from the sim models when sim=1.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with write_en=4'hF -> write_ack at +1, err=0. Then read 0x10 -> at +3: ack=1, data=0xDEADBEEF, addr_ack=0x10.
- Write 0x0000AB00 to 0x20 with write_en=4'b0010 over prior content 0x11223344 -> a read of 0x20 returns 0x1122AB44.
- Reads of 0x1, 0x2, 0x3 on consecutive cycles -> three consecutive acks with the matching addr_ack and data. Repeat with READ_LATENCY=1 and READ_LATENCY=4.
- Read 0x4000 with SRAM_WORDS=16384 -> ack at +3, err=1, data=0. A write to 0x4000 -> write_ack with err=1, and RAM word 0x0000 is unchanged.
- read_en together with write_en=4'hF to 0x30 -> write done and acked; read acked with err=1. A later read of 0x30 returns the written value.
- Reads in flight, then sync_reset pulsed at T+1 -> no read_ack appears. Separately, reset_n asserted mid-pipeline -> all outputs 0 immediately.
